video_timing_capture: RTL and testbench

- Receive-side counterpart to video_gen.
- Samples video_gen's sync, active and pixel outputs on the pixel clock.
- Measures horizontal and vertical timing, publishes one timing set per frame, and reports lock when two consecutive frames match.
- Packs active pixels into bytes on a write port so the Pi side or the bench can read back the rendered frame.

---
 rtl/video_timing_capture.sv | 179 +++++++++++++++++
 tb/tb_video_timing_capture.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_capture.sv
// Receive-side timing analyser for video_gen: measures h/v timing once per frame,
// flags lock on two identical frames, and packs active pixels into bytes.
module video_timing_capture #(
  parameter int unsigned H_W    = 12,
  parameter int unsigned V_W    = 10,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              pixel_clk_i,
  input  logic              reset_i,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic              h_active_i,
  input  logic              v_active_i,
  input  logic              video_i,
  output logic [H_W-1:0]    h_total_o,
  output logic [H_W-1:0]    h_active_o,
  output logic [H_W-1:0]    h_sync_width_o,
  output logic [V_W-1:0]    v_total_o,
  output logic [V_W-1:0]    v_active_o,
  output logic [V_W-1:0]    v_sync_width_o,
  output logic              frame_valid_o,
  output logic              locked_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [V_W-1:0] V_MAX = '1;

  logic hs_q, vs_q, ha_q;
  logic hs_rise, hs_fall, vs_rise, vs_fall, ha_rise;

  logic [H_W-1:0] h_cnt, hsw_cnt, ha_cnt;
  logic [H_W-1:0] h_total_s, h_sync_width_s, h_active_s;
  logic [V_W-1:0] line_cnt, va_cnt, vsw_cnt;
  logic [V_W-1:0] v_total_s, v_active_s, v_sync_width_s;
  logic           pub_q, have_prev, same_set, h_sat, l_sat;

  logic              qual, byte_done;
  logic [7:0]        sh, flush_byte;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr;

  assign hs_rise = h_sync_i & ~hs_q;
  assign hs_fall = ~h_sync_i & hs_q;
  assign vs_rise = v_sync_i & ~vs_q;
  assign vs_fall = ~v_sync_i & vs_q;
  assign ha_rise = h_active_i & ~ha_q;
  assign h_sat   = (h_cnt == H_MAX);
  assign l_sat   = (line_cnt == V_MAX);

  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      ha_q <= 1'b0;
    end else begin
      hs_q <= h_sync_i;
      vs_q <= v_sync_i;
      ha_q <= h_active_i;
    end
  end

  // Horizontal measurements; the hs_rise cycle itself counts toward the new line.
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      h_cnt          <= '0;
      hsw_cnt        <= '0;
      ha_cnt         <= '0;
      h_total_s      <= '0;
      h_sync_width_s <= '0;
      h_active_s     <= '0;
    end else begin
      if (hs_rise) begin
        h_cnt      <= '0;
        h_total_s  <= h_sat ? H_MAX : h_cnt + H_W'(1);
        h_active_s <= ha_cnt;
        ha_cnt     <= H_W'(h_active_i);
        hsw_cnt    <= H_W'(1);
      end else begin
        if (!h_sat) h_cnt <= h_cnt + H_W'(1);
        if (h_active_i && ha_cnt != H_MAX) ha_cnt <= ha_cnt + H_W'(1);
        if (h_sync_i && hsw_cnt != H_MAX) hsw_cnt <= hsw_cnt + H_W'(1);
      end
      if (hs_fall) h_sync_width_s <= hsw_cnt;
    end
  end

  // Vertical measurements; an hs_rise coincident with vs_rise belongs to the new frame.
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      line_cnt       <= '0;
      va_cnt         <= '0;
      vsw_cnt        <= '0;
      v_total_s      <= '0;
      v_active_s     <= '0;
      v_sync_width_s <= '0;
    end else begin
      if (vs_rise) begin
        v_total_s  <= line_cnt;
        v_active_s <= va_cnt;
        line_cnt   <= V_W'(hs_rise);
        va_cnt     <= V_W'(ha_rise & v_active_i);
        vsw_cnt    <= V_W'(hs_rise);
      end else begin
        if (hs_rise && !l_sat) line_cnt <= line_cnt + V_W'(1);
        if (ha_rise && v_active_i && va_cnt != V_MAX) va_cnt <= va_cnt + V_W'(1);
        if (hs_rise && v_sync_i && vsw_cnt != V_MAX) vsw_cnt <= vsw_cnt + V_W'(1);
      end
      if (vs_fall) v_sync_width_s <= vsw_cnt;
    end
  end

  assign same_set = ({h_total_s, h_active_s, h_sync_width_s, v_total_s, v_active_s, v_sync_width_s} ==
                     {h_total_o, h_active_o, h_sync_width_o, v_total_o, v_active_o, v_sync_width_o});

  // Publish one cycle after vs_rise; counter saturation overrides lock.
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      pub_q          <= 1'b0;
      have_prev      <= 1'b0;
      frame_valid_o  <= 1'b0;
      locked_o       <= 1'b0;
      h_total_o      <= '0;
      h_active_o     <= '0;
      h_sync_width_o <= '0;
      v_total_o      <= '0;
      v_active_o     <= '0;
      v_sync_width_o <= '0;
    end else begin
      pub_q         <= vs_rise;
      frame_valid_o <= 1'b0;
      if (pub_q) begin
        h_total_o      <= h_total_s;
        h_active_o     <= h_active_s;
        h_sync_width_o <= h_sync_width_s;
        v_total_o      <= v_total_s;
        v_active_o     <= v_active_s;
        v_sync_width_o <= v_sync_width_s;
        frame_valid_o  <= 1'b1;
        locked_o       <= have_prev & same_set;
        have_prev      <= 1'b1;
      end
      if (h_sat || l_sat) locked_o <= 1'b0;
    end
  end

  assign qual       = h_active_i & v_active_i;
  assign byte_done  = qual ? (cnt == 3'd7) : (cnt != 3'd0);
  assign flush_byte = sh << (4'd8 - {1'b0, cnt});

  // Pixel packer: full bytes and end-of-run partial bytes, first pixel in bit 7.
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      sh        <= '0;
      cnt       <= '0;
      addr      <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= byte_done;
      if (byte_done) begin
        wr_addr_o <= addr;
        wr_data_o <= qual ? {sh[6:0], video_i} : flush_byte;
      end
      if (qual) begin
        sh  <= {sh[6:0], video_i};
        cnt <= cnt + 3'd1;
      end else begin
        cnt <= 3'd0;
      end
      if (vs_rise) addr <= '0;
      else if (byte_done) addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_video_timing_capture.sv
// Randomised bench for video_timing_capture: a frame-level model predicts each
// published timing set and every captured byte; a monitor pops and compares.
module tb_video_timing_capture;

  localparam int unsigned H_W    = 12;
  localparam int unsigned V_W    = 10;
  localparam int unsigned ADDR_W = 11;
  localparam int V_ACT    = 16;
  localparam int VS_START = 24;
  localparam int VS_END   = 32;
  localparam int V_LINES  = 40;

  logic pixel_clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic h_sync_i = 1'b0, v_sync_i = 1'b0, h_active_i = 1'b0, v_active_i = 1'b0, video_i = 1'b0;
  logic [H_W-1:0]    h_total_o, h_active_o, h_sync_width_o;
  logic [V_W-1:0]    v_total_o, v_active_o, v_sync_width_o;
  logic              frame_valid_o, locked_o, wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;

  always #5 pixel_clk_i = ~pixel_clk_i;

  video_timing_capture #(.H_W(H_W), .V_W(V_W), .ADDR_W(ADDR_W)) dut (
    .pixel_clk_i(pixel_clk_i), .reset_i(reset_i),
    .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .h_active_i(h_active_i),
    .v_active_i(v_active_i), .video_i(video_i),
    .h_total_o(h_total_o), .h_active_o(h_active_o), .h_sync_width_o(h_sync_width_o),
    .v_total_o(v_total_o), .v_active_o(v_active_o), .v_sync_width_o(v_sync_width_o),
    .frame_valid_o(frame_valid_o), .locked_o(locked_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  typedef struct { int ht; int ha; int hsw; int vt; int va; int vsw; int lk; } frame_t;
  typedef struct { int addr; int data; } wr_t;

  frame_t fq[$];
  wr_t    wq[$];
  int total = 0;
  int bad   = 0;

  // Frame-level model state
  frame_t prev;
  int have_prev = 0;
  int last_lk = 0;
  int lines_since_vs = 0;
  int va_since_vs = 0;
  int last_vsw = 0;
  int exp_addr = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  frame_t mf;
  wr_t    mw;
  always @(negedge pixel_clk_i) begin
    if (frame_valid_o) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame_valid: got pulse expected none (t=%0t)", $time);
      end else begin
        mf = fq.pop_front();
        chk("h_total", int'(h_total_o), mf.ht);
        chk("h_active", int'(h_active_o), mf.ha);
        chk("h_sync_width", int'(h_sync_width_o), mf.hsw);
        chk("v_total", int'(v_total_o), mf.vt);
        chk("v_active", int'(v_active_o), mf.va);
        chk("v_sync_width", int'(v_sync_width_o), mf.vsw);
        chk("locked_at_publish", int'(locked_o), mf.lk);
      end
    end
    if (wr_en_o) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none (t=%0t)",
                 wr_addr_o, wr_data_o, $time);
      end else begin
        mw = wq.pop_front();
        chk("wr_addr", int'(wr_addr_o), mw.addr);
        chk("wr_data", int'(wr_data_o), mw.data);
      end
    end
  end

  task automatic drive_line(input int line, input int ha, input int ht, input int hsw,
                            input int mode, input int ncyc);
    int px[64];
    frame_t e;
    wr_t w;
    int d;
    if (line == VS_START) begin
      e.ht = ht; e.ha = ha; e.hsw = hsw;
      e.vt = lines_since_vs; e.va = va_since_vs; e.vsw = last_vsw;
      e.lk = (have_prev != 0 && e.ht == prev.ht && e.ha == prev.ha && e.hsw == prev.hsw &&
              e.vt == prev.vt && e.va == prev.va && e.vsw == prev.vsw) ? 1 : 0;
      fq.push_back(e);
      prev = e; have_prev = 1; last_lk = e.lk;
      lines_since_vs = 0; va_since_vs = 0; exp_addr = 0;
    end
    if (line == VS_END) last_vsw = VS_END - VS_START;
    lines_since_vs++;
    if (line < V_ACT) va_since_vs++;
    for (int p = 0; p < 64; p++)
      px[p] = (p >= ha) ? 0 : (mode == 0) ? ((p == 0) ? 1 : 0) :
              (mode == 1) ? 1 : int'($urandom_range(0, 1));
    if (line < V_ACT) begin
      for (int b = 0; b < (ha + 7) / 8; b++) begin
        d = 0;
        for (int k = 0; k < 8; k++) d = d | (px[b*8+k] << (7 - k));
        w.addr = exp_addr; w.data = d;
        wq.push_back(w);
        exp_addr = (exp_addr + 1) % (1 << ADDR_W);
      end
    end
    for (int p = 0; p < ncyc; p++) begin
      @(posedge pixel_clk_i); #1;
      h_sync_i   = (p >= ht - hsw);
      v_sync_i   = (line >= VS_START && line < VS_END);
      h_active_i = (p < ha);
      v_active_i = (line < V_ACT);
      video_i    = (p < ha && line < V_ACT) ? 1'(px[p]) : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_frame(input int ha, input int ht, input int hsw, input int mode);
    for (int l = 0; l < V_LINES; l++) drive_line(l, ha, ht, hsw, mode, ht);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pixel_clk_i); #1;
      h_sync_i = 1'b0; v_sync_i = 1'b0; h_active_i = 1'b0; v_active_i = 1'b0; video_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    chk("frames_outstanding_before_reset", fq.size(), 0);
    @(posedge pixel_clk_i); #1;
    reset_i = 1'b0;
    h_sync_i = 1'b0; v_sync_i = 1'b0; h_active_i = 1'b0; v_active_i = 1'b0; video_i = 1'b0;
    repeat (3) @(posedge pixel_clk_i);
    wq.delete();
    have_prev = 0; last_lk = 0; lines_since_vs = 0; va_since_vs = 0; last_vsw = 0; exp_addr = 0;
    @(negedge pixel_clk_i);
    chk("rst_h_total", int'(h_total_o), 0);
    chk("rst_h_active", int'(h_active_o), 0);
    chk("rst_h_sync_width", int'(h_sync_width_o), 0);
    chk("rst_v_total", int'(v_total_o), 0);
    chk("rst_v_active", int'(v_active_o), 0);
    chk("rst_v_sync_width", int'(v_sync_width_o), 0);
    chk("rst_frame_valid", int'(frame_valid_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_wr_en", int'(wr_en_o), 0);
    chk("rst_wr_addr", int'(wr_addr_o), 0);
    chk("rst_wr_data", int'(wr_data_o), 0);
    @(posedge pixel_clk_i); #1;
    reset_i = 1'b1;
  endtask

  initial begin
    int ha, hsw, ht;
    do_reset();
    idle(10);
    repeat (3) drive_frame(24, 48, 8, 0);
    repeat (2) drive_frame(20, 48, 8, 1);
    repeat (2) drive_frame(24, 50, 8, 2);
    ha  = int'($urandom_range(9, 30));
    hsw = int'($urandom_range(4, 10));
    ht  = ha + int'($urandom_range(2, 10)) + hsw;
    drive_frame(ha, ht, hsw, 2);
    repeat (2) drive_frame(24, 50, 8, 2);
    idle(2);
    @(negedge pixel_clk_i);
    chk("locked_before_idle", int'(locked_o), last_lk);
    idle(4200);
    @(negedge pixel_clk_i);
    chk("locked_after_h_saturation", int'(locked_o), 0);
    repeat (2) drive_frame(24, 48, 8, 2);
    for (int l = 0; l < 5; l++) drive_line(l, 24, 48, 8, 2, 48);
    drive_line(5, 24, 48, 8, 2, 10);
    do_reset();
    repeat (2) drive_frame(24, 48, 8, 0);
    idle(20);
    @(negedge pixel_clk_i);
    chk("frames_outstanding_at_end", fq.size(), 0);
    chk("writes_outstanding_at_end", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
